// File: rtl/bid_round_logger.sv
// Logs one record per bid round into a first-word fall-through FIFO and
// keeps saturating per-bidder win counters plus a wrapping round number.
module bid_round_logger #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             roundOver,
    input  logic             X_win,
    input  logic             Y_win,
    input  logic             Z_win,
    input  logic [31:0]      maxBid,
    input  logic             rd_ready,
    input  logic             clr_stats,
    output logic             rd_valid,
    output logic [7:0]       rd_round,
    output logic [1:0]       rd_winner,
    output logic [31:0]      rd_maxBid,
    output logic [CNT_W-1:0] X_wins,
    output logic [CNT_W-1:0] Y_wins,
    output logic [CNT_W-1:0] Z_wins,
    output logic [7:0]       round_cnt,
    output logic             overflow,
    output logic             win_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic             roundOver_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [7:0]  mem_round  [DEPTH];
    logic [1:0]  mem_winner [DEPTH];
    logic [31:0] mem_bid    [DEPTH];

    logic       capture;
    logic       fifo_full;
    logic       pop;
    logic       push;
    logic       drop;
    logic [1:0] win_code;
    logic       win_bad;

    assign capture   = roundOver & ~roundOver_d;
    assign rd_valid  = (count != '0);
    assign fifo_full = (count == FULL_CNT);
    assign pop       = rd_valid & rd_ready;
    // A full FIFO can still accept a record when the head leaves in the same cycle.
    assign push      = capture & (~fifo_full | pop);
    assign drop      = capture & fifo_full & ~pop;

    assign rd_round  = rd_valid ? mem_round[rd_ptr]  : 8'd0;
    assign rd_winner = rd_valid ? mem_winner[rd_ptr] : 2'd0;
    assign rd_maxBid = rd_valid ? mem_bid[rd_ptr]    : 32'd0;

    always_comb begin
        win_code = 2'd0;
        win_bad  = 1'b0;
        case ({X_win, Y_win, Z_win})
            3'b100:  win_code = 2'd1;
            3'b010:  win_code = 2'd2;
            3'b001:  win_code = 2'd3;
            default: win_bad  = 1'b1;
        endcase
    end

    // Clear takes effect first so a win in the clearing cycle still counts.
    function automatic logic [CNT_W-1:0] next_win(input logic [CNT_W-1:0] cur,
                                                  input logic clr,
                                                  input logic hit);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (hit && (base != '1))
            base = base + 1'b1;
        return base;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            roundOver_d <= 1'b0;
            round_cnt   <= 8'd0;
            X_wins      <= '0;
            Y_wins      <= '0;
            Z_wins      <= '0;
            overflow    <= 1'b0;
            win_err     <= 1'b0;
        end else begin
            roundOver_d <= roundOver;
            if (capture)
                round_cnt <= round_cnt + 8'd1;
            X_wins   <= next_win(X_wins, clr_stats, capture && (win_code == 2'd1));
            Y_wins   <= next_win(Y_wins, clr_stats, capture && (win_code == 2'd2));
            Z_wins   <= next_win(Z_wins, clr_stats, capture && (win_code == 2'd3));
            overflow <= (overflow & ~clr_stats) | drop;
            win_err  <= (win_err & ~clr_stats) | (capture & win_bad);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_round[i]  <= 8'd0;
                mem_winner[i] <= 2'd0;
                mem_bid[i]    <= 32'd0;
            end
        end else begin
            if (push) begin
                mem_round[wr_ptr]  <= round_cnt;
                mem_winner[wr_ptr] <= win_code;
                mem_bid[wr_ptr]    <= maxBid;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bid_round_logger.sv
// Directed bench for bid_round_logger with DEPTH=4 and CNT_W=2 so that
// overflow and counter saturation are reached in a few rounds.
module tb_bid_round_logger;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             reset;
    logic             roundOver;
    logic             X_win;
    logic             Y_win;
    logic             Z_win;
    logic [31:0]      maxBid;
    logic             rd_ready;
    logic             clr_stats;
    logic             rd_valid;
    logic [7:0]       rd_round;
    logic [1:0]       rd_winner;
    logic [31:0]      rd_maxBid;
    logic [CNT_W-1:0] X_wins;
    logic [CNT_W-1:0] Y_wins;
    logic [CNT_W-1:0] Z_wins;
    logic [7:0]       round_cnt;
    logic             overflow;
    logic             win_err;

    int checks = 0;
    int errors = 0;

    bid_round_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .roundOver(roundOver),
        .X_win(X_win),
        .Y_win(Y_win),
        .Z_win(Z_win),
        .maxBid(maxBid),
        .rd_ready(rd_ready),
        .clr_stats(clr_stats),
        .rd_valid(rd_valid),
        .rd_round(rd_round),
        .rd_winner(rd_winner),
        .rd_maxBid(rd_maxBid),
        .X_wins(X_wins),
        .Y_wins(Y_wins),
        .Z_wins(Z_wins),
        .round_cnt(round_cnt),
        .overflow(overflow),
        .win_err(win_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic applyStimulus(input logic ro, input logic x, input logic y, input logic z,
                                 input logic [31:0] bid, input logic ready, input logic clr);
        roundOver = ro;
        X_win     = x;
        Y_win     = y;
        Z_win     = z;
        maxBid    = bid;
        rd_ready  = ready;
        clr_stats = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkHead(input string tag, input logic valid, input logic [7:0] rnd,
                             input logic [1:0] winner, input logic [31:0] bid);
        checkOutput({tag, ".rd_valid"},  {31'd0, rd_valid},  {31'd0, valid});
        checkOutput({tag, ".rd_round"},  {24'd0, rd_round},  {24'd0, rnd});
        checkOutput({tag, ".rd_winner"}, {30'd0, rd_winner}, {30'd0, winner});
        checkOutput({tag, ".rd_maxBid"}, rd_maxBid, bid);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // One round: a roundOver pulse followed by one idle cycle.
    task automatic captureRound(input logic x, input logic y, input logic z,
                                input logic [31:0] bid, input logic ready);
        applyStimulus(1'b1, x, y, z, bid, ready, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, ready, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;

        checkHead("reset", 1'b0, 8'd0, 2'd0, 32'd0);
        checkOutput("reset.X_wins", 32'(X_wins), 32'd0);
        checkOutput("reset.Y_wins", 32'(Y_wins), 32'd0);
        checkOutput("reset.Z_wins", 32'(Z_wins), 32'd0);
        checkOutput("reset.round_cnt", 32'(round_cnt), 32'd0);
        checkOutput("reset.overflow", 32'(overflow), 32'd0);
        checkOutput("reset.win_err", 32'(win_err), 32'd0);

        // Y wins, roundOver held for three cycles yields a single record
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 1'b0, 1'b0);
        checkHead("y_round", 1'b1, 8'd0, 2'd2, 32'h50);
        checkOutput("y_round.Y_wins", 32'(Y_wins), 32'd1);
        checkOutput("y_round.round_cnt", 32'(round_cnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 1'b0, 1'b0);
        checkOutput("y_hold.round_cnt", 32'(round_cnt), 32'd1);
        checkOutput("y_hold.Y_wins", 32'(Y_wins), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkHead("y_drained", 1'b0, 8'd0, 2'd0, 32'd0);

        // Two rounds buffered, then drained in order
        doReset();
        captureRound(1'b1, 1'b0, 1'b0, 32'h10, 1'b0);
        captureRound(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
        checkHead("two.first", 1'b1, 8'd0, 2'd1, 32'h10);
        checkOutput("two.round_cnt", 32'(round_cnt), 32'd2);
        checkOutput("two.X_wins", 32'(X_wins), 32'd1);
        checkOutput("two.Z_wins", 32'(Z_wins), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkHead("two.second", 1'b1, 8'd1, 2'd3, 32'h20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkHead("two.empty", 1'b0, 8'd0, 2'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkHead("two.ready_on_empty", 1'b0, 8'd0, 2'd0, 32'd0);

        // DEPTH+1 captures without popping: last record dropped
        doReset();
        for (int i = 0; i < DEPTH; i++)
            captureRound(1'b0, 1'b0, 1'b1, 32'h100 + i, 1'b0);
        checkOutput("ovf.before", 32'(overflow), 32'd0);
        captureRound(1'b0, 1'b0, 1'b1, 32'h1FF, 1'b0);
        checkOutput("ovf.flag", 32'(overflow), 32'd1);
        checkOutput("ovf.round_cnt", 32'(round_cnt), 32'(DEPTH + 1));
        checkOutput("ovf.Z_wins_sat", 32'(Z_wins), 32'd3);
        for (int i = 0; i < DEPTH; i++) begin
            checkHead($sformatf("ovf.drain%0d", i), 1'b1, 8'(i), 2'd3, 32'h100 + i);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        end
        checkHead("ovf.empty", 1'b0, 8'd0, 2'd0, 32'd0);

        // Full FIFO with capture and pop together keeps occupancy at DEPTH
        doReset();
        for (int i = 0; i < DEPTH; i++)
            captureRound(1'b1, 1'b0, 1'b0, 32'h200 + i, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h2AA, 1'b1, 1'b0);
        checkOutput("fullpop.overflow", 32'(overflow), 32'd0);
        checkHead("fullpop.head", 1'b1, 8'd1, 2'd1, 32'h201);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            checkHead($sformatf("fullpop.drain%0d", i), 1'b1, 8'(i), 2'd1, 32'h200 + i);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        end
        checkHead("fullpop.tail", 1'b1, 8'(DEPTH), 2'd1, 32'h2AA);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkHead("fullpop.empty", 1'b0, 8'd0, 2'd0, 32'd0);
        // capture with rd_ready on an empty FIFO: write happens, pop ignored
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h3C, 1'b1, 1'b0);
        checkHead("emptypop", 1'b1, 8'(DEPTH + 1), 2'd2, 32'h3C);

        // Multi-hot and zero-hot winners, then clr_stats interactions
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h33, 1'b0, 1'b0);
        checkHead("multi", 1'b1, 8'd0, 2'd0, 32'h33);
        checkOutput("multi.win_err", 32'(win_err), 32'd1);
        checkOutput("multi.X_wins", 32'(X_wins), 32'd0);
        checkOutput("multi.Y_wins", 32'(Y_wins), 32'd0);
        checkOutput("multi.round_cnt", 32'(round_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("clr.win_err", 32'(win_err), 32'd0);
        checkOutput("clr.rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("clr.round_cnt", 32'(round_cnt), 32'd1);
        captureRound(1'b1, 1'b0, 1'b0, 32'h44, 1'b0);
        checkOutput("x_once.X_wins", 32'(X_wins), 32'd1);
        captureRound(1'b0, 1'b0, 1'b0, 32'h55, 1'b0);
        checkOutput("zero_hot.win_err", 32'(win_err), 32'd1);
        checkOutput("zero_hot.X_wins", 32'(X_wins), 32'd1);
        checkOutput("zero_hot.round_cnt", 32'(round_cnt), 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h66, 1'b0, 1'b1);
        checkOutput("clr_cap.X_wins", 32'(X_wins), 32'd1);
        checkOutput("clr_cap.win_err", 32'(win_err), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        captureRound(1'b1, 1'b0, 1'b0, 32'h77, 1'b0);
        checkOutput("clr_ovf.overflow", 32'(overflow), 32'd1);
        checkOutput("clr_ovf.X_wins", 32'(X_wins), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("clr2.overflow", 32'(overflow), 32'd0);
        checkOutput("clr2.X_wins", 32'(X_wins), 32'd0);
        checkOutput("clr2.round_cnt", 32'(round_cnt), 32'd5);
        checkHead("clr2.head", 1'b1, 8'd0, 2'd0, 32'h33);

        // 256 X rounds with continuous draining: round_cnt wraps, X_wins sticks at 3
        doReset();
        for (int i = 0; i < 256; i++) begin
            captureRound(1'b1, 1'b0, 1'b0, 32'(i), 1'b1);
            if (i == 2)
                checkOutput("wrap.X_wins_at3", 32'(X_wins), 32'd3);
            if (i == 4)
                checkOutput("wrap.X_wins_at5", 32'(X_wins), 32'd3);
            if (i == 254)
                checkOutput("wrap.round_cnt255", 32'(round_cnt), 32'd255);
        end
        checkOutput("wrap.round_cnt", 32'(round_cnt), 32'd0);
        checkOutput("wrap.overflow", 32'(overflow), 32'd0);
        checkOutput("wrap.rd_valid", 32'(rd_valid), 32'd0);

        // Reset wins over a same-cycle capture; roundOver high after reset captures
        captureRound(1'b0, 1'b1, 1'b0, 32'h88, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h99, 1'b1, 1'b0);
        reset = 1'b0;
        checkHead("rst_prio", 1'b0, 8'd0, 2'd0, 32'd0);
        checkOutput("rst_prio.round_cnt", 32'(round_cnt), 32'd0);
        checkOutput("rst_prio.X_wins", 32'(X_wins), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h99, 1'b0, 1'b0);
        checkHead("post_rst", 1'b1, 8'd0, 2'd1, 32'h99);
        checkOutput("post_rst.X_wins", 32'(X_wins), 32'd1);
        checkOutput("post_rst.round_cnt", 32'(round_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bid_round_logger.md
Name: bid_round_logger

Overview:
- Downstream stage of the bid controller. Consumes its round-result outputs: roundOver, X_win/Y_win/Z_win and maxBid.
- Captures exactly one record per round and buffers the records in a FIFO. A host drains the FIFO through a valid/ready port.
- Keeps saturating per-bidder win counters and a round-sequence number for audit and scoreboarding.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.
- CNT_W, 8: width of each per-bidder win counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- roundOver  in  1  round-over flag from the bid controller; stays high while it remains in the round-over state.
- X_win  in  1  X won the round; valid while roundOver=1.
- Y_win  in  1  Y won the round; valid while roundOver=1.
- Z_win  in  1  Z won the round; valid while roundOver=1.
- maxBid  in  32  winning total bid; valid while roundOver=1.
- rd_ready  in  1  host accepts the head record.
- clr_stats  in  1  clears the win counters and sticky flags.
- rd_valid  out  1  FIFO not empty.
- rd_round  out  8  round id of the head record.
- rd_winner  out  2  winner code of the head record: 0 none, 1 X, 2 Y, 3 Z.
- rd_maxBid  out  32  maxBid of the head record.
- X_wins  out  CNT_W  rounds won by X.
- Y_wins  out  CNT_W  rounds won by Y.
- Z_wins  out  CNT_W  rounds won by Z.
- round_cnt  out  8  rounds captured.
- overflow  out  1  sticky; a record was dropped because the FIFO was full.
- win_err  out  1  sticky; win inputs were multi-hot or all-zero at capture.

Behaviour:
- Reset value of every output and register is 0: FIFO empty, rd_* outputs 0, counters 0, flags 0, round_cnt 0. Reset takes priority over all other inputs, including mid-drain and a same-cycle capture.
- Capture event: roundOver=1 while the registered previous roundOver=0. Capture happens once per rising edge.
  - The controller can go round-over -> round-active -> round-over. Each fresh rising edge is a new round.
  - roundOver held high for many cycles produces one record.
  - roundOver_d also resets to 0, so roundOver already high on the first cycle after reset counts as a capture.
- Winner encoding at capture:
  - Exactly one of X_win/Y_win/Z_win high gives code 1, 2 or 3, and the matching counter increments.
  - Zero or more than one high gives code 0. No counter changes and win_err is set.
- Record format: {round_cnt value before increment, winner code, maxBid}. round_cnt increments on every capture, including dropped or erroneous ones, and wraps from 255 to 0.
- Win counters saturate at 2^CNT_W-1.
- Latency: a capture detected in cycle N writes the FIFO at the end of N. rd_valid is high in cycle N+1 if the FIFO was empty. Counters and round_cnt update at the end of N.
- FIFO:
  - First-word fall-through. rd_* always show the head record when rd_valid=1, and 0 when empty.
  - Pop happens when rd_valid and rd_ready are both high.
  - rd_ready while empty is ignored.
  - Read and write pointers wrap modulo DEPTH.
- Full FIFO:
  - A capture with no pop in the same cycle drops the record and sets overflow. Counters and round_cnt still update.
  - Capture and pop in the same cycle, full or not, are both performed and occupancy is unchanged.
  - Capture and pop in the same cycle on an empty FIFO: the pop is ignored and the write happens.
- clr_stats:
  - Next cycle, X/Y/Z_wins, overflow and win_err are 0. FIFO contents and round_cnt are unaffected.
  - A capture in the same cycle as clr_stats: clear wins, then the new win is counted (counter = 1) and any new error flag is set.
- No combinational path from inputs to outputs. All outputs are registered or driven directly from FIFO storage.

Test Plan:
- Reset, then roundOver rising with Y_win=1 and maxBid=0x50 for 3 cycles -> one record {0, 2, 0x50}; rd_valid=1 one cycle after the edge; Y_wins=1; round_cnt=1.
- Two rounds (X with 0x10, then Z with 0x20) separated by a roundOver low cycle, with rd_ready=0, then drain with rd_ready=1 -> records pop in order {0,1,0x10} then {1,3,0x20}; rd_valid drops after the second pop.
- DEPTH+1 captures with no pops -> first DEPTH records retained; overflow=1; round_cnt=DEPTH+1; the last record is absent when draining.
- FIFO full, capture and pop in the same cycle -> occupancy stays DEPTH, overflow stays 0, the new record is at the tail.
- Capture with X_win=Y_win=1 -> winner code 0, win_err=1, no counter changes; then clr_stats -> win_err=0 and all wins counters 0.
- 256 captures with draining -> round_cnt wraps to 0; with CNT_W=2, the X counter sticks at 3 after 5 X wins.
